// File: rtl/sd_rx_word_packer.sv
// rtl/sd_rx_word_packer.sv - packs the SD read nibble stream into 32-bit words behind a FWFT word FIFO
// The packer assembles 8 nibbles per word and pushes on the edge that takes the 8th nibble.

module sd_rx_word_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sd_clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [31:0]           push_data,
  input  logic                  pop_req,
  output logic [31:0]           rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  push_ok
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign rd_data = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the same-edge push needs.
  assign pop_ok  = pop_req & ~empty & ~clr;
  assign push_ok = push & ~clr & (~full | pop_ok);

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

module sd_rx_word_packer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  sd_clk,
  input  logic                  rst,
  input  logic [3:0]            nib_in,
  input  logic                  nib_we,
  input  logic                  clr,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           word_cnt
);

  logic [2:0]  nidx;
  logic [31:0] partial;
  logic [4:0]  slot_lsb;
  logic [31:0] merged;
  logic        word_done;
  logic        push_ok;

  always_comb begin
    slot_lsb = '0;
    if (BIG_ENDIAN != 0) begin
      slot_lsb = 5'd28 - {nidx, 2'b00};
    end else begin
      slot_lsb = {nidx, 2'b00};
    end
  end

  // Masked insert keeps the merge correct even if stale bits sat in the slot.
  assign merged    = (partial & ~(32'hF << slot_lsb)) | ({28'd0, nib_in} << slot_lsb);
  assign word_done = nib_we & (nidx == 3'd7);

  sd_rx_word_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .clr        (clr),
    .push       (word_done),
    .push_data  (merged),
    .pop_req    (rd_en),
    .rd_data    (rd_data),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .push_ok    (push_ok)
  );

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      nidx     <= '0;
      partial  <= '0;
      overflow <= 1'b0;
      word_cnt <= '0;
    end else if (clr) begin
      nidx     <= '0;
      partial  <= '0;
      overflow <= 1'b0;
      word_cnt <= '0;
    end else if (nib_we) begin
      nidx    <= nidx + 3'd1;
      partial <= word_done ? 32'd0 : merged;
      if (word_done && push_ok) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (word_done && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_rx_word_packer.sv
// tb/tb_sd_rx_word_packer.sv - directed checks of the nibble packer in both nibble orders
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.

module tb_sd_rx_word_packer;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic [3:0]  nib_in;
  logic        nib_we;
  logic        clr;
  logic        rd_en;

  logic [31:0] rd_data_be, rd_data_le;
  logic        empty_be, empty_le, full_be, full_le;
  logic [3:0]  level_be, level_le;
  logic        overflow_be, overflow_le;
  logic [15:0] word_cnt_be, word_cnt_le;

  int checks = 0;
  int errors = 0;

  always #5 sd_clk = ~sd_clk;

  sd_rx_word_packer #(.DEPTH_LOG2(3), .BIG_ENDIAN(1)) dut_be (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .nib_in   (nib_in),
    .nib_we   (nib_we),
    .clr      (clr),
    .rd_en    (rd_en),
    .rd_data  (rd_data_be),
    .empty    (empty_be),
    .full     (full_be),
    .level    (level_be),
    .overflow (overflow_be),
    .word_cnt (word_cnt_be)
  );

  sd_rx_word_packer #(.DEPTH_LOG2(3), .BIG_ENDIAN(0)) dut_le (
    .sd_clk   (sd_clk),
    .rst      (rst),
    .nib_in   (nib_in),
    .nib_we   (nib_we),
    .clr      (clr),
    .rd_en    (rd_en),
    .rd_data  (rd_data_le),
    .empty    (empty_le),
    .full     (full_le),
    .level    (level_le),
    .overflow (overflow_le),
    .word_cnt (word_cnt_le)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    nib_in = n;
    nib_we = 1'b1;
    step();
    nib_we = 1'b0;
    repeat (gap) step();
  endtask

  // Nibbles go out most-significant first, so the big-endian DUT rebuilds w unchanged.
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_nib(w[31-4*i -: 4], gap);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] word_k(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  initial begin
    rst    = 1'b1;
    nib_in = 4'h0;
    nib_we = 1'b0;
    clr    = 1'b0;
    rd_en  = 1'b0;
    step();
    step();

    check("rst_empty_be",    {31'd0, empty_be},    32'd1);
    check("rst_full_be",     {31'd0, full_be},     32'd0);
    check("rst_level_be",    {28'd0, level_be},    32'd0);
    check("rst_overflow_be", {31'd0, overflow_be}, 32'd0);
    check("rst_word_cnt_be", {16'd0, word_cnt_be}, 32'd0);
    check("rst_rd_data_be",  rd_data_be,           32'd0);
    check("rst_empty_le",    {31'd0, empty_le},    32'd1);
    check("rst_full_le",     {31'd0, full_le},     32'd0);
    check("rst_level_le",    {28'd0, level_le},    32'd0);
    check("rst_overflow_le", {31'd0, overflow_le}, 32'd0);
    check("rst_word_cnt_le", {16'd0, word_cnt_le}, 32'd0);
    check("rst_rd_data_le",  rd_data_le,           32'd0);
    rst = 1'b0;
    step();

    // Test 1: back-to-back nibbles 1..8
    send_word(32'h1234_5678, 0);
    check("t1_empty",    {31'd0, empty_be},     32'd0);
    check("t1_level",    {28'd0, level_be},     32'd1);
    check("t1_rd_be",    rd_data_be,            32'h1234_5678);
    check("t1_rd_le",    rd_data_le,            32'h8765_4321);
    check("t1_word_cnt", {16'd0, word_cnt_be},  32'd1);

    // Test 2: same nibbles with 3 idle cycles between strobes, then one pop
    pulse_clr();
    check("t2_clr_level", {28'd0, level_le}, 32'd0);
    send_word(32'h1234_5678, 3);
    check("t2_rd_le",    rd_data_le,           32'h8765_4321);
    check("t2_rd_be",    rd_data_be,           32'h1234_5678);
    check("t2_level_le", {28'd0, level_le},    32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t2_pop_empty", {31'd0, empty_le},   32'd1);
    check("t2_pop_level", {28'd0, level_le},   32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t2_empty_pop_level", {28'd0, level_le},    32'd0);
    check("t2_empty_pop_ovf",   {31'd0, overflow_le}, 32'd0);

    // Test 3: fill to 8 words, 9th is dropped
    pulse_clr();
    for (int k = 1; k <= 8; k++) send_word(word_k(k), 0);
    check("t3_full",     {31'd0, full_be},     32'd1);
    check("t3_level",    {28'd0, level_be},    32'd8);
    check("t3_ovf_pre",  {31'd0, overflow_be}, 32'd0);
    send_word(word_k(9), 0);
    check("t3_ovf",      {31'd0, overflow_be}, 32'd1);
    check("t3_level9",   {28'd0, level_be},    32'd8);
    check("t3_word_cnt", {16'd0, word_cnt_be}, 32'd8);
    check("t3_head",     rd_data_be,           word_k(1));

    // Test 4: push and pop on the same edge while full
    pulse_clr();
    check("t4_clr_ovf", {31'd0, overflow_be}, 32'd0);
    for (int k = 1; k <= 8; k++) send_word(word_k(k), 0);
    for (int i = 0; i < 7; i++) send_nib(word_k(9) >> (28 - 4*i), 0);
    nib_in = word_k(9) & 32'hF;
    nib_we = 1'b1;
    rd_en  = 1'b1;
    step();
    nib_we = 1'b0;
    rd_en  = 1'b0;
    check("t4_level",    {28'd0, level_be},    32'd8);
    check("t4_ovf",      {31'd0, overflow_be}, 32'd0);
    check("t4_word_cnt", {16'd0, word_cnt_be}, 32'd9);
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("t4_drain_%0d", k), rd_data_be, word_k(k));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    check("t4_empty", {31'd0, empty_be}, 32'd1);

    // Test 5: clr on the same edge as a nibble strobe, mid-word
    pulse_clr();
    for (int i = 0; i < 5; i++) send_nib(4'h9, 0);
    nib_in = 4'h5;
    nib_we = 1'b1;
    clr    = 1'b1;
    step();
    nib_we = 1'b0;
    clr    = 1'b0;
    check("t5_clr_level", {28'd0, level_be}, 32'd0);
    send_word(32'hABCD_EF01, 0);
    check("t5_rd_be",     rd_data_be,           32'hABCD_EF01);
    check("t5_rd_le",     rd_data_le,           32'h10FE_DCBA);
    check("t5_word_cnt",  {16'd0, word_cnt_be}, 32'd1);
    check("t5_level",     {28'd0, level_be},    32'd1);

    // Test 6: asynchronous reset between edges with 3 words and a partial word held
    pulse_clr();
    for (int k = 1; k <= 3; k++) send_word(word_k(k), 0);
    for (int i = 0; i < 3; i++) send_nib(4'hF, 0);
    check("t6_level_pre", {28'd0, level_be}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_empty",    {31'd0, empty_be},     32'd1);
    check("t6_level",    {28'd0, level_be},     32'd0);
    check("t6_ovf",      {31'd0, overflow_be},  32'd0);
    check("t6_word_cnt", {16'd0, word_cnt_be},  32'd0);
    step();
    rst = 1'b0;
    step();
    send_word(32'h1357_2468, 0);
    check("t6_new_level", {28'd0, level_be},    32'd1);
    check("t6_new_cnt",   {16'd0, word_cnt_be}, 32'd1);
    check("t6_new_rd_be", rd_data_be,           32'h1357_2468);
    check("t6_new_rd_le", rd_data_le,           32'h8642_7531);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
